// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN front-end loader and its input RAM.
package snn_pkg;

  typedef enum logic [2:0] {
    LOAD,
    UNPACK,
    START,
    WAIT_DONE,
    SEND
  } loader_state_t;

  localparam int FRAME_BITS = 784;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/ram_input_unit.sv
// Single-bit-wide input-unit RAM: one synchronous write port, one registered read port.
module ram_input_unit
  import snn_pkg::*;
#(
  parameter int DEPTH  = FRAME_BITS,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              q
);

  logic mem [DEPTH];

  // Storage is deliberately left unreset; only the read register has a defined reset value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Receives a packed binary image byte-by-byte, unpacks it into the input-unit RAM,
// launches the core, and forwards the classification result as ASCII to the UART.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int FRAME_BYTES = 98
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_vld,
  input  logic [7:0] rx_data,
  input  logic [9:0] addr_input_unit,
  output logic       q_input,
  output logic       start,
  input  logic       done,
  input  logic [3:0] digit,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       overrun
);

  localparam int DEPTH = FRAME_BYTES * 8;

  loader_state_t state, state_nxt;

  logic [6:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [3:0] res;
  logic       res_vld;
  logic       last_bit;
  logic       last_byte;
  logic       accept;

  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == 7'(FRAME_BYTES - 1));
  assign accept    = (state == LOAD) && rx_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:      if (rx_vld) state_nxt = UNPACK;
      UNPACK:    if (last_bit) state_nxt = last_byte ? START : LOAD;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done) state_nxt = SEND;
      SEND:      if (!tx_busy) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  // tx_start is decoded from SEND but held off while the transmitter is still busy.
  assign start    = (state == START);
  assign busy     = (state != LOAD);
  assign tx_start = (state == SEND) && !tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 7'd0;
      bit_cnt  <= 3'd0;
    end else if (state == UNPACK) begin
      bit_cnt <= bit_cnt + 3'd1;
      if (last_bit) begin
        byte_cnt <= last_byte ? 7'd0 : byte_cnt + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= rx_data;
    end else if (state == UNPACK) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

  // The result is captured at done so the ASCII byte is already stable when tx_start rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res     <= 4'd0;
      res_vld <= 1'b0;
    end else if ((state == WAIT_DONE) && done) begin
      res     <= digit;
      res_vld <= 1'b1;
    end
  end

  assign tx_data = res_vld ? to_ascii(res) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (rx_vld) begin
      if (state != LOAD) begin
        overrun <= 1'b1;
      end else if (byte_cnt == 7'd0) begin
        overrun <= 1'b0;
      end
    end
  end

  ram_input_unit #(
    .DEPTH  (DEPTH),
    .ADDR_W (10)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (state == UNPACK),
    .waddr ({byte_cnt, bit_cnt}),
    .wdata (shreg[0]),
    .raddr (addr_input_unit),
    .q     (q_input)
  );

endmodule
